// File: rtl/acc_tree_pkg.sv
// acc_tree_pkg
// Shared constants and elaboration-time helpers for the accumulating adder
// tree: default parameter values, ceil(log2), per-level width and per-level
// element count of the pairwise reduction.
package acc_tree_pkg;

  localparam int DEF_N_IN  = 27;
  localparam int DEF_IN_W  = 16;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_SH_W  = 5;

  // ceil(log2(n)); 0 for n <= 1
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  // Number of registered tree levels; a single input still gets one level so
  // the pipeline depth never collapses to zero.
  function automatic int tree_depth(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  // Width of the values produced by level j (level 0 is the raw input)
  function automatic int lvl_w(input int in_w, input int j);
    return in_w + j;
  endfunction

  // Element count at level j: ceil(n / 2^j)
  function automatic int lvl_n(input int n, input int j);
    return (n + (1 << j) - 1) >> j;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level
// One registered level of a signed pairwise reduction. Adjacent pairs are
// summed with one bit of growth; an odd trailing element is sign-extended
// and passed through.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, clears the output register
//   din   N_IN packed signed values of IN_W bits, element k at [k*IN_W +: IN_W]
//   dout  ceil(N_IN/2) packed signed values of IN_W+1 bits
module adder_tree_level
  import acc_tree_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int IN_W = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_IN*IN_W-1:0]                     din,
  output logic [lvl_n(N_IN, 1)*(IN_W+1)-1:0]       dout
);

  localparam int N_OUT = lvl_n(N_IN, 1);
  localparam int O_W   = IN_W + 1;

  logic [N_OUT*O_W-1:0] sum_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN / 2; gi++) begin : g_pair
      logic [IN_W-1:0] a;
      logic [IN_W-1:0] b;
      assign a = din[2*gi*IN_W +: IN_W];
      assign b = din[(2*gi+1)*IN_W +: IN_W];
      assign sum_next[gi*O_W +: O_W] = {a[IN_W-1], a} + {b[IN_W-1], b};
    end
    if (N_IN % 2 == 1) begin : g_odd
      logic [IN_W-1:0] a;
      assign a = din[(N_IN-1)*IN_W +: IN_W];
      assign sum_next[(N_OUT-1)*O_W +: O_W] = {a[IN_W-1], a};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) dout <= '0;
    else     dout <= sum_next;
  end

endmodule

// File: rtl/acc_adder_tree.sv
// acc_adder_tree
// Pipelined signed adder tree with multi-beat group accumulation and output
// requantisation (round half-up, arithmetic right shift, saturation).
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   vld_i       beat valid (no backpressure)
//   first_i     beat opens a new group
//   last_i      beat closes the group
//   data_i      N_IN packed signed products of IN_W bits
//   shift_i     right-shift amount, taken from the last beat of a group
//   rnd_en_i    round half-up enable, taken from the last beat of a group
//   vld_o       one-cycle pulse per group result
//   acc_o       saturated OUT_W-bit result, held between pulses
//   sat_o       result was clamped, held between pulses
module acc_adder_tree
  import acc_tree_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SH_W  = DEF_SH_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld_i,
  input  logic                   first_i,
  input  logic                   last_i,
  input  logic [N_IN*IN_W-1:0]   data_i,
  input  logic [SH_W-1:0]        shift_i,
  input  logic                   rnd_en_i,
  output logic                   vld_o,
  output logic [OUT_W-1:0]       acc_o,
  output logic                   sat_o
);

  localparam int L     = tree_depth(N_IN);
  localparam int SUM_W = lvl_w(IN_W, L);
  localparam int SB_W  = SH_W + 4;

  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  // ---------------- reduction tree ----------------
  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_lvl
      logic [lvl_n(N_IN, gi)*lvl_w(IN_W, gi)-1:0]         d;
      logic [lvl_n(N_IN, gi+1)*lvl_w(IN_W, gi+1)-1:0]     q;
      if (gi == 0) begin : g_src
        assign d = data_i;
      end else begin : g_src
        assign d = g_lvl[gi-1].q;
      end
      adder_tree_level #(
        .N_IN (lvl_n(N_IN, gi)),
        .IN_W (lvl_w(IN_W, gi))
      ) u_level (
        .clk  (clk),
        .rst  (rst),
        .din  (d),
        .dout (q)
      );
    end
  endgenerate

  logic [SUM_W-1:0]        tree_sum;
  logic signed [ACC_W-1:0] sum_ext;
  assign tree_sum = g_lvl[L-1].q;
  assign sum_ext  = ACC_W'($signed(tree_sum));

  // ---------------- sideband pipe, aligned with the tree ----------------
  logic [SB_W-1:0] sb_pipe_reg [L];
  logic            sb_vld, sb_first, sb_last, sb_rnd;
  logic [SH_W-1:0] sb_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) sb_pipe_reg[i] <= '0;
    end else begin
      sb_pipe_reg[0] <= {vld_i, first_i, last_i, rnd_en_i, shift_i};
      for (int i = 1; i < L; i++) sb_pipe_reg[i] <= sb_pipe_reg[i-1];
    end
  end

  assign {sb_vld, sb_first, sb_last, sb_rnd, sb_shift} = sb_pipe_reg[L-1];

  // ---------------- accumulator ----------------
  logic signed [ACC_W-1:0] acc_q;
  logic                    grp_open_reg;  // previous valid beat was not a last
  logic                    fire_reg;      // acc_q holds a completed group
  logic [SH_W-1:0]         shift_reg;
  logic                    rnd_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      grp_open_reg <= 1'b0;
      fire_reg     <= 1'b0;
      shift_reg    <= '0;
      rnd_reg      <= 1'b0;
    end else begin
      fire_reg <= sb_vld & sb_last;
      if (sb_vld) begin
        // An explicit first discards whatever partial sum was open
        if (sb_first || !grp_open_reg) acc_q <= sum_ext;
        else                           acc_q <= acc_q + sum_ext;
        grp_open_reg <= !sb_last;
        shift_reg    <= sb_shift;
        rnd_reg      <= sb_rnd;
      end
    end
  end

  // ---------------- requantiser ----------------
  // One extra bit of headroom so the rounding increment cannot wrap.
  logic [SH_W-1:0]         sh_m1;
  logic signed [ACC_W:0]   rnd_add, t_val, r_val;
  logic [OUT_W-1:0]        acc_next;
  logic                    sat_next;

  assign sh_m1   = shift_reg - SH_W'(1);
  assign rnd_add = (rnd_reg && shift_reg != '0) ? ((ACC_W+1)'(1) << sh_m1) : '0;
  assign t_val   = {acc_q[ACC_W-1], acc_q} + rnd_add;
  assign r_val   = t_val >>> shift_reg;

  always_comb begin
    acc_next = r_val[OUT_W-1:0];
    sat_next = 1'b0;
    if (r_val > MAX_V) begin
      acc_next = MAX_V[OUT_W-1:0];
      sat_next = 1'b1;
    end else if (r_val < MIN_V) begin
      acc_next = MIN_V[OUT_W-1:0];
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_o <= 1'b0;
      acc_o <= '0;
      sat_o <= 1'b0;
    end else begin
      vld_o <= fire_reg;
      if (fire_reg) begin
        acc_o <= acc_next;
        sat_o <= sat_next;
      end
    end
  end

endmodule

// File: doc/acc_adder_tree.md
# acc_adder_tree

Parametrised, fully pipelined signed adder tree with multi-beat accumulation and output requantisation. Reduces `N_IN` signed products per beat to one sum, optionally accumulates sums across a group of beats (input-channel tiling when a filter is wider than one beat), then shifts, rounds and saturates the group total to `OUT_W` bits. Sits between the multiplier array and the activation/quantisation stage of a conv layer; it replaces the fixed 27-input, 16-bit tree used in layer 0.

## Interface
- `N_IN`, 27: products per beat; must be ≥ 1.
- `IN_W`, 16: width of each signed product.
- `ACC_W`, 32: accumulator width; must be ≥ `IN_W + clog2(N_IN)`.
- `OUT_W`, 16: output width; must be ≤ `ACC_W`.
- `SH_W`, 5: width of the shift-amount port.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `vld_i`  in  1  beat valid; no backpressure.
- `first_i`  in  1  beat opens a new group (qualified by `vld_i`).
- `last_i`  in  1  beat closes the group (qualified by `vld_i`).
- `data_i`  in  `N_IN*IN_W`  packed signed products; element k is at `[k*IN_W +: IN_W]`.
- `shift_i`  in  `SH_W`  arithmetic right-shift for the group; sampled on the last beat.
- `rnd_en_i`  in  1  round half-up before the shift; sampled on the last beat.
- `vld_o`  out  1  one-cycle pulse marking a group result.
- `acc_o`  out  `OUT_W`  signed, saturated group result.
- `sat_o`  out  1  result was clamped; qualified by `vld_o`.

## Operation
- **Tree**
  - `L = clog2(N_IN)` registered levels, with `L = 1` when `N_IN = 1`.
  - Level j adds adjacent pairs. An odd trailing element passes through, sign-extended, unchanged.
  - Every operand is sign-extended. Level j is `IN_W + j` bits wide.
  - `vld_i`, `first_i`, `last_i`, `shift_i` and `rnd_en_i` travel alongside the data in a matching L-deep pipeline.
- **Accumulator**, stage L+1, register `acc_q` of `ACC_W` bits:
  - A beat starts a group if `first_i = 1` or the previous valid beat had `last_i = 1`. Reset counts as a preceding last. A group start does `acc_q <= sext(tree_sum)`.
  - Any other valid beat does `acc_q <= acc_q + sext(tree_sum)`. Overflow wraps modulo 2^ACC_W; it is not flagged.
  - Invalid cycles hold `acc_q`. Gaps inside a group are allowed.
  - `first_i` and `last_i` both high gives a single-beat group.
  - `first_i` in the middle of a group discards the partial sum and restarts. There is no output for the discarded group.
- **Requantise**, stage L+2, on the cycle after a last beat reaches `acc_q`:
  - `t = acc_q + (rnd_en && sh != 0 ? 1 << (sh-1) : 0)`, computed in `ACC_W+1` bits.
  - `r = t >>> sh`. A shift of `sh ≥ ACC_W` yields the sign fill (0 or -1).
  - If r is above 2^(OUT_W-1)-1 or below -2^(OUT_W-1), clamp to that bound and set `sat_o = 1`.
  - Register `acc_o` and `sat_o`, and pulse `vld_o`.
- **Between results:** `acc_o` and `sat_o` hold their last values while `vld_o = 0`.

## Timing
- Latency from a `vld_i && last_i` beat to `vld_o` is exactly L+2 cycles. For the defaults this is 7.
- Throughput: one beat per cycle. Back-to-back single-beat groups give `vld_o` on consecutive cycles.
- Reset values: `vld_o = 0`, `acc_o = 0`, `sat_o = 0`. All tree levels, sideband pipes and `acc_q` clear to 0.
- Reset mid-operation:
  - Every in-flight beat and any partial group is dropped.
  - `vld_o` is 0 in the cycle after `rst` is sampled high and for L+2 cycles after release, unless new beats arrive.
  - The first valid beat after reset always starts a group.
- `data_i` and the sideband inputs are sampled only when `vld_i = 1`. Otherwise they are don't-care.

## Structure
- Package `acc_tree_pkg`:
  - `clog2` function.
  - Level-width function `lvl_w(j) = IN_W + j`.
  - Level-count function `lvl_n(j) = ceil(N_IN / 2^j)`.
  - Default parameter constants.
- Sub-module `adder_tree_level`:
  - Parameters: input count, input width.
  - Generic registered pairwise reduction with odd pass-through.
  - Instantiated L times in a generate loop.
- The top holds the sideband pipe, accumulator, requantiser and output registers.

## Test plan
- **Single-beat sum:** defaults, all 27 inputs = 1, `first = last = 1`, shift 0 → `acc_o = 27`, `vld_o` 7 cycles after `vld_i`, `sat_o = 0`.
- **Signed extremes:** all inputs = -32768 with shift 0 → clamped to -32768, `sat_o = 1`. Same inputs with shift 5 → -27648, no saturation.
- **Three-beat group:** inputs per beat all 100, 200, -50, with a 2-cycle `vld_i` gap inside the group → single `vld_o` with 27·250 = 6750. Shift 2 with `rnd_en` → 1688.
- **Restart and back-to-back:** `first_i` mid-group discards the partial sum (no `vld_o` for it). Then four single-beat groups on consecutive cycles → four consecutive `vld_o` pulses with the correct sums.
- **Reset mid-group:** `rst` pulsed during the second beat of a group. Then a fresh group of all 2 with `last = 1` → `acc_o = 54`; no stale output appears before it.
- **Parameter sweep:** `N_IN` ∈ {1, 2, 5, 27, 64} with random data → the result matches a reference sum, and latency equals `clog2(N_IN) + 2` (3 for `N_IN = 1`).
